// File: rtl/interrupt_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_sequencer
// Description : Reset/interrupt front end of the 65C02 core. Synchronises the
//               irqb/nmib pins, latches NMI falling edges, arbitrates pending
//               events (NMI > IRQ) at instruction boundaries, issues the
//               5-bit vector-operation request to instruction_decode and then
//               runs the two-cycle vector-pull address sequence.
// Ports       : fclk              core clock (rising edge)
//               resb              async active-low reset (RESB pin)
//               irqb              IRQ pin, active-low, level
//               nmib              NMI pin, active-low, falling edge
//               rdy               advance enable; low freezes FSM and outputs
//               sync              opcode-fetch (instruction boundary) strobe
//               i_flag            processor status I bit
//               vec_ack           decoder accepts the current vector request
//               vector_operations {push_vector,push_resb,push_nmib,push_irqb,
//                                  reset_stack}
//               vector_addr       vector fetch address (valid with vector_pull)
//               vector_pull       high during the two vector fetch cycles
//               int_pending       an event is latched and waiting (IDLE only)
//               busy              high in every state except IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_sequencer #(
    parameter int SYNC_STAGES  = 2,
    parameter int RESET_CYCLES = 7
) (
    input  logic        fclk,
    input  logic        resb,
    input  logic        irqb,
    input  logic        nmib,
    input  logic        rdy,
    input  logic        sync,
    input  logic        i_flag,
    input  logic        vec_ack,
    output logic [4:0]  vector_operations,
    output logic [15:0] vector_addr,
    output logic        vector_pull,
    output logic        int_pending,
    output logic        busy
);

    localparam logic [2:0] c_ST_RST_HOLD = 3'd0;
    localparam logic [2:0] c_ST_IDLE     = 3'd1;
    localparam logic [2:0] c_ST_REQ      = 3'd2;
    localparam logic [2:0] c_ST_VEC_LO   = 3'd3;
    localparam logic [2:0] c_ST_VEC_HI   = 3'd4;

    localparam logic [1:0] c_KIND_RESET  = 2'd0;
    localparam logic [1:0] c_KIND_NMI    = 2'd1;
    localparam logic [1:0] c_KIND_IRQ    = 2'd2;

    localparam logic [3:0] c_HOLD_LAST   = 4'(RESET_CYCLES - 1);

    logic [2:0]             state_q, state_d;
    logic [1:0]             kind_q, kind_d;
    logic [3:0]             hold_cnt_q, hold_cnt_d;
    logic [SYNC_STAGES-1:0] irq_sync_q, irq_sync_d;
    logic [SYNC_STAGES-1:0] nmi_sync_q, nmi_sync_d;
    logic                   nmi_prev_q, nmi_prev_d;
    logic                   nmi_latch_q, nmi_latch_d;
    logic [4:0]             vec_ops_q, vec_ops_d;
    logic [15:0]            vec_addr_q, vec_addr_d;
    logic                   vec_pull_q, vec_pull_d;
    logic                   int_pend_q, int_pend_d;
    logic                   busy_q, busy_d;

    logic                   irq_s, nmi_s, irq_req, nmi_fall, nmi_clr;
    logic [15:0]            lo_addr;

    assign irq_s = irq_sync_q[SYNC_STAGES-1];
    assign nmi_s = nmi_sync_q[SYNC_STAGES-1];

    always_comb begin
        irq_sync_d = {irq_sync_q[SYNC_STAGES-2:0], irqb};
        nmi_sync_d = {nmi_sync_q[SYNC_STAGES-2:0], nmib};
        nmi_prev_d = nmi_s;

        irq_req  = ~irq_s & ~i_flag;
        nmi_fall = nmi_prev_q & ~nmi_s;
        // The latch is cleared only by the accepted NMI request; a new edge
        // on that same cycle keeps it set so the event is not lost.
        nmi_clr     = rdy & vec_ack & (state_q == c_ST_REQ) & (kind_q == c_KIND_NMI);
        nmi_latch_d = nmi_fall | (nmi_latch_q & ~nmi_clr);

        state_d    = state_q;
        kind_d     = kind_q;
        hold_cnt_d = hold_cnt_q;

        if (rdy) begin
            case (state_q)
                c_ST_RST_HOLD: begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                    if (hold_cnt_q == c_HOLD_LAST) begin
                        kind_d  = c_KIND_RESET;
                        state_d = c_ST_REQ;
                    end
                end
                c_ST_IDLE: begin
                    if (sync) begin
                        if (nmi_latch_q) begin
                            kind_d  = c_KIND_NMI;
                            state_d = c_ST_REQ;
                        end else if (irq_req) begin
                            kind_d  = c_KIND_IRQ;
                            state_d = c_ST_REQ;
                        end
                    end
                end
                c_ST_REQ: begin
                    if (vec_ack) begin
                        state_d = c_ST_VEC_LO;
                    end
                end
                c_ST_VEC_LO: state_d = c_ST_VEC_HI;
                c_ST_VEC_HI: state_d = c_ST_IDLE;
                default:     state_d = c_ST_IDLE;
            endcase
        end

        case (kind_d)
            c_KIND_RESET: lo_addr = 16'hFFFC;
            c_KIND_NMI:   lo_addr = 16'hFFFA;
            default:      lo_addr = 16'hFFFE;
        endcase

        // Outputs are registered images of the next state, so a request
        // appears on the cycle after the decision that commits it.
        vec_ops_d  = 5'b00000;
        vec_addr_d = 16'h0000;
        vec_pull_d = 1'b0;
        case (state_d)
            c_ST_REQ: begin
                case (kind_d)
                    c_KIND_RESET: vec_ops_d = 5'b11001;
                    c_KIND_NMI:   vec_ops_d = 5'b10100;
                    default:      vec_ops_d = 5'b10010;
                endcase
            end
            c_ST_VEC_LO: begin
                vec_pull_d = 1'b1;
                vec_addr_d = lo_addr;
            end
            c_ST_VEC_HI: begin
                vec_pull_d = 1'b1;
                vec_addr_d = lo_addr + 16'd1;
            end
            default: ;
        endcase

        busy_d     = (state_d != c_ST_IDLE);
        int_pend_d = rdy ? ((state_d == c_ST_IDLE) & (nmi_latch_d | irq_req)) : int_pend_q;
    end

    always_ff @(posedge fclk or negedge resb) begin
        if (!resb) begin
            state_q     <= c_ST_RST_HOLD;
            kind_q      <= c_KIND_RESET;
            hold_cnt_q  <= 4'd0;
            irq_sync_q  <= '1;
            nmi_sync_q  <= '1;
            nmi_prev_q  <= 1'b1;
            nmi_latch_q <= 1'b0;
            vec_ops_q   <= 5'b00000;
            vec_addr_q  <= 16'h0000;
            vec_pull_q  <= 1'b0;
            int_pend_q  <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            hold_cnt_q  <= hold_cnt_d;
            irq_sync_q  <= irq_sync_d;
            nmi_sync_q  <= nmi_sync_d;
            nmi_prev_q  <= nmi_prev_d;
            nmi_latch_q <= nmi_latch_d;
            vec_ops_q   <= vec_ops_d;
            vec_addr_q  <= vec_addr_d;
            vec_pull_q  <= vec_pull_d;
            int_pend_q  <= int_pend_d;
            busy_q      <= busy_d;
        end
    end

    assign vector_operations = vec_ops_q;
    assign vector_addr       = vec_addr_q;
    assign vector_pull       = vec_pull_q;
    assign int_pending       = int_pend_q;
    assign busy              = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_interrupt_sequencer
// Description : Self-checking bench for interrupt_sequencer: directed reset,
//               IRQ, NMI priority, NMI-during-service, rdy stall and
//               mid-sequence reset scenarios, plus a randomized arbitration
//               loop checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_sequencer;

    localparam int S  = 2;
    localparam int RC = 7;

    localparam int K_RESET = 0;
    localparam int K_NMI   = 1;
    localparam int K_IRQ   = 2;
    localparam int K_NONE  = 3;

    logic        fclk = 1'b0;
    logic        resb, irqb, nmib, rdy, sync, i_flag, vec_ack;
    logic [4:0]  vector_operations;
    logic [15:0] vector_addr;
    logic        vector_pull, int_pending, busy;

    int checks = 0;
    int errors = 0;

    interrupt_sequencer #(.SYNC_STAGES(S), .RESET_CYCLES(RC)) dut (
        .fclk              (fclk),
        .resb              (resb),
        .irqb              (irqb),
        .nmib              (nmib),
        .rdy               (rdy),
        .sync              (sync),
        .i_flag            (i_flag),
        .vec_ack           (vec_ack),
        .vector_operations (vector_operations),
        .vector_addr       (vector_addr),
        .vector_pull       (vector_pull),
        .int_pending       (int_pending),
        .busy              (busy)
    );

    always #5 fclk = ~fclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Reference tables: request code and low vector address per event kind.
    function automatic logic [4:0] exp_ops(int k);
        case (k)
            K_RESET: return 5'b11001;
            K_NMI:   return 5'b10100;
            K_IRQ:   return 5'b10010;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic logic [15:0] exp_lo(int k);
        case (k)
            K_RESET: return 16'hFFFC;
            K_NMI:   return 16'hFFFA;
            default: return 16'hFFFE;
        endcase
    endfunction

    // {ops, pull, addr, busy}
    function automatic logic [22:0] pk(logic [4:0] o, logic p, logic [15:0] a, logic b);
        return {o, p, a, b};
    endfunction

    function automatic logic [22:0] obs();
        return {vector_operations, vector_pull, vector_addr, busy};
    endfunction

    task automatic tick(int n);
        repeat (n) begin
            @(posedge fclk);
            #1;
        end
    endtask

    task automatic test_reset();
        resb = 1'b0; irqb = 1'b1; nmib = 1'b1; rdy = 1'b1;
        sync = 1'b0; i_flag = 1'b0; vec_ack = 1'b0;
        tick(3);
        if (obs() !== pk(5'b0, 1'b0, 16'h0, 1'b1) || int_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got=%h ip=%b want=%h ip=0", obs(), int_pending, pk(5'b0, 1'b0, 16'h0, 1'b1));
        end
        checks++;
        resb = 1'b1;
        tick(RC - 1);
        if (obs() !== pk(5'b0, 1'b0, 16'h0, 1'b1)) begin
            errors++;
            $display("FAIL reset_hold_early got=%h want=%h", obs(), pk(5'b0, 1'b0, 16'h0, 1'b1));
        end
        checks++;
        tick(1);
        if (obs() !== pk(5'b11001, 1'b0, 16'h0, 1'b1)) begin
            errors++;
            $display("FAIL reset_req got=%h want=%h", obs(), pk(5'b11001, 1'b0, 16'h0, 1'b1));
        end
        checks++;
        vec_ack = 1'b1; tick(1); vec_ack = 1'b0;
        if (obs() !== pk(5'b0, 1'b1, 16'hFFFC, 1'b1)) begin
            errors++;
            $display("FAIL reset_vec_lo got=%h want=%h", obs(), pk(5'b0, 1'b1, 16'hFFFC, 1'b1));
        end
        checks++;
        tick(1);
        if (obs() !== pk(5'b0, 1'b1, 16'hFFFD, 1'b1)) begin
            errors++;
            $display("FAIL reset_vec_hi got=%h want=%h", obs(), pk(5'b0, 1'b1, 16'hFFFD, 1'b1));
        end
        checks++;
        tick(1);
        if (obs() !== pk(5'b0, 1'b0, 16'h0, 1'b0)) begin
            errors++;
            $display("FAIL reset_idle got=%h want=%h", obs(), pk(5'b0, 1'b0, 16'h0, 1'b0));
        end
        checks++;
    endtask

    task automatic test_irq();
        irqb = 1'b0; i_flag = 1'b0;
        tick(S + 2);
        if (int_pending !== 1'b1) begin
            errors++;
            $display("FAIL irq_pending got=%b want=1", int_pending);
        end
        checks++;
        sync = 1'b1; tick(1); sync = 1'b0;
        if (obs() !== pk(5'b10010, 1'b0, 16'h0, 1'b1) || int_pending !== 1'b0) begin
            errors++;
            $display("FAIL irq_req got=%h ip=%b want=%h ip=0", obs(), int_pending, pk(5'b10010, 1'b0, 16'h0, 1'b1));
        end
        checks++;
        i_flag = 1'b1;  // ignored outside IDLE
        tick(2);
        if (obs() !== pk(5'b10010, 1'b0, 16'h0, 1'b1)) begin
            errors++;
            $display("FAIL irq_req_held got=%h want=%h", obs(), pk(5'b10010, 1'b0, 16'h0, 1'b1));
        end
        checks++;
        vec_ack = 1'b1; tick(1); vec_ack = 1'b0;
        if (obs() !== pk(5'b0, 1'b1, 16'hFFFE, 1'b1)) begin
            errors++;
            $display("FAIL irq_vec_lo got=%h want=%h", obs(), pk(5'b0, 1'b1, 16'hFFFE, 1'b1));
        end
        checks++;
        tick(1);
        if (obs() !== pk(5'b0, 1'b1, 16'hFFFF, 1'b1)) begin
            errors++;
            $display("FAIL irq_vec_hi got=%h want=%h", obs(), pk(5'b0, 1'b1, 16'hFFFF, 1'b1));
        end
        checks++;
        tick(2);
        if (obs() !== pk(5'b0, 1'b0, 16'h0, 1'b0) || int_pending !== 1'b0) begin
            errors++;
            $display("FAIL irq_masked_idle got=%h ip=%b want=%h ip=0", obs(), int_pending, pk(5'b0, 1'b0, 16'h0, 1'b0));
        end
        checks++;
        sync = 1'b1; tick(1); sync = 1'b0;
        vec_ack = 1'b1; tick(1); vec_ack = 1'b0;
        if (obs() !== pk(5'b0, 1'b0, 16'h0, 1'b0)) begin
            errors++;
            $display("FAIL irq_masked_sync got=%h want=%h", obs(), pk(5'b0, 1'b0, 16'h0, 1'b0));
        end
        checks++;
        irqb = 1'b1; i_flag = 1'b0;
        tick(S + 2);
    endtask

    task automatic test_nmi_priority();
        nmib = 1'b0; irqb = 1'b0; i_flag = 1'b0;
        tick(S + 3);
        for (int pass = 0; pass < 2; pass++) begin
            int k = (pass == 0) ? K_NMI : K_IRQ;
            sync = 1'b1; tick(1); sync = 1'b0;
            if (obs() !== pk(exp_ops(k), 1'b0, 16'h0, 1'b1)) begin
                errors++;
                $display("FAIL prio_req%0d got=%h want=%h", pass, obs(), pk(exp_ops(k), 1'b0, 16'h0, 1'b1));
            end
            checks++;
            vec_ack = 1'b1; tick(1); vec_ack = 1'b0;
            tick(1);
            if (obs() !== pk(5'b0, 1'b1, exp_lo(k) + 16'd1, 1'b1)) begin
                errors++;
                $display("FAIL prio_vec_hi%0d got=%h want=%h", pass, obs(), pk(5'b0, 1'b1, exp_lo(k) + 16'd1, 1'b1));
            end
            checks++;
            tick(1);
        end
        nmib = 1'b1; irqb = 1'b1;
        tick(S + 2);
    endtask

    task automatic test_nmi_during_irq();
        irqb = 1'b0;
        tick(S + 2);
        sync = 1'b1; tick(1); sync = 1'b0;
        vec_ack = 1'b1; tick(1); vec_ack = 1'b0;
        if (obs() !== pk(5'b0, 1'b1, 16'hFFFE, 1'b1)) begin
            errors++;
            $display("FAIL nmi_in_irq_lo got=%h want=%h", obs(), pk(5'b0, 1'b1, 16'hFFFE, 1'b1));
        end
        checks++;
        nmib = 1'b0; irqb = 1'b1;
        tick(1);
        nmib = 1'b1;
        if (obs() !== pk(5'b0, 1'b1, 16'hFFFF, 1'b1)) begin
            errors++;
            $display("FAIL nmi_in_irq_hi got=%h want=%h", obs(), pk(5'b0, 1'b1, 16'hFFFF, 1'b1));
        end
        checks++;
        tick(S + 3);
        if (int_pending !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL nmi_in_irq_pending ip=%b busy=%b want ip=1 busy=0", int_pending, busy);
        end
        checks++;
        sync = 1'b1; tick(1); sync = 1'b0;
        if (obs() !== pk(5'b10100, 1'b0, 16'h0, 1'b1)) begin
            errors++;
            $display("FAIL nmi_after_irq got=%h want=%h", obs(), pk(5'b10100, 1'b0, 16'h0, 1'b1));
        end
        checks++;
        vec_ack = 1'b1; tick(1); vec_ack = 1'b0;
        tick(2);
    endtask

    task automatic test_rdy_stall();
        irqb = 1'b0;
        tick(S + 2);
        sync = 1'b1; tick(1); sync = 1'b0;
        rdy = 1'b0; tick(4);
        if (obs() !== pk(5'b10010, 1'b0, 16'h0, 1'b1)) begin
            errors++;
            $display("FAIL stall_req got=%h want=%h", obs(), pk(5'b10010, 1'b0, 16'h0, 1'b1));
        end
        checks++;
        rdy = 1'b1;
        vec_ack = 1'b1; tick(1); vec_ack = 1'b0;
        irqb = 1'b1;
        rdy = 1'b0; tick(4);
        if (obs() !== pk(5'b0, 1'b1, 16'hFFFE, 1'b1)) begin
            errors++;
            $display("FAIL stall_vec_lo got=%h want=%h", obs(), pk(5'b0, 1'b1, 16'hFFFE, 1'b1));
        end
        checks++;
        rdy = 1'b1; tick(1);
        if (obs() !== pk(5'b0, 1'b1, 16'hFFFF, 1'b1)) begin
            errors++;
            $display("FAIL stall_resume got=%h want=%h", obs(), pk(5'b0, 1'b1, 16'hFFFF, 1'b1));
        end
        checks++;
        tick(1);
        // Freeze the hold counter part-way through the reset hold.
        resb = 1'b0; tick(1); resb = 1'b1;
        tick(3);
        rdy = 1'b0; tick(10);
        rdy = 1'b1; tick(RC - 4);
        if (obs() !== pk(5'b0, 1'b0, 16'h0, 1'b1)) begin
            errors++;
            $display("FAIL stall_hold_early got=%h want=%h", obs(), pk(5'b0, 1'b0, 16'h0, 1'b1));
        end
        checks++;
        tick(1);
        if (obs() !== pk(5'b11001, 1'b0, 16'h0, 1'b1)) begin
            errors++;
            $display("FAIL stall_hold_req got=%h want=%h", obs(), pk(5'b11001, 1'b0, 16'h0, 1'b1));
        end
        checks++;
        vec_ack = 1'b1; tick(1); vec_ack = 1'b0;
        tick(2);
    endtask

    task automatic test_reset_mid();
        nmib = 1'b0;
        tick(S + 3);
        sync = 1'b1; tick(1); sync = 1'b0;
        nmib = 1'b1;
        vec_ack = 1'b1; nmib = 1'b0; tick(1); vec_ack = 1'b0; nmib = 1'b1;
        tick(1);
        if (obs() !== pk(5'b0, 1'b1, 16'hFFFB, 1'b1)) begin
            errors++;
            $display("FAIL mid_vec_hi got=%h want=%h", obs(), pk(5'b0, 1'b1, 16'hFFFB, 1'b1));
        end
        checks++;
        #2 resb = 1'b0;
        #1;
        if (obs() !== pk(5'b0, 1'b0, 16'h0, 1'b1) || int_pending !== 1'b0) begin
            errors++;
            $display("FAIL mid_async_clear got=%h ip=%b want=%h ip=0", obs(), int_pending, pk(5'b0, 1'b0, 16'h0, 1'b1));
        end
        checks++;
        tick(2);
        resb = 1'b1;
        tick(RC - 1);
        if (obs() !== pk(5'b0, 1'b0, 16'h0, 1'b1)) begin
            errors++;
            $display("FAIL mid_hold_early got=%h want=%h", obs(), pk(5'b0, 1'b0, 16'h0, 1'b1));
        end
        checks++;
        tick(1);
        if (obs() !== pk(5'b11001, 1'b0, 16'h0, 1'b1)) begin
            errors++;
            $display("FAIL mid_reset_req got=%h want=%h", obs(), pk(5'b11001, 1'b0, 16'h0, 1'b1));
        end
        checks++;
        vec_ack = 1'b1; tick(1); vec_ack = 1'b0;
        if (obs() !== pk(5'b0, 1'b1, 16'hFFFC, 1'b1)) begin
            errors++;
            $display("FAIL mid_vec_lo got=%h want=%h", obs(), pk(5'b0, 1'b1, 16'hFFFC, 1'b1));
        end
        checks++;
        tick(1);
        if (obs() !== pk(5'b0, 1'b1, 16'hFFFD, 1'b1)) begin
            errors++;
            $display("FAIL mid_vec_hi2 got=%h want=%h", obs(), pk(5'b0, 1'b1, 16'hFFFD, 1'b1));
        end
        checks++;
        tick(2);
        sync = 1'b1; tick(1); sync = 1'b0;
        if (obs() !== pk(5'b0, 1'b0, 16'h0, 1'b0) || int_pending !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_nmi got=%h ip=%b want=%h ip=0", obs(), int_pending, pk(5'b0, 1'b0, 16'h0, 1'b0));
        end
        checks++;
    endtask

    // Random events at boundaries, checked against a model that tracks a
    // pending-NMI flag and applies NMI > (IRQ and not masked) priority.
    task automatic test_random();
        bit nmi_pend = 1'b0;
        for (int it = 0; it < 40; it++) begin
            bit nmi_edge = 1'($urandom_range(0, 1));
            bit irq_low  = 1'($urandom_range(0, 1));
            bit iflag    = 1'($urandom_range(0, 1));
            int dly      = int'($urandom_range(0, 3));
            int k;
            if (nmi_edge) begin
                nmib = 1'b0; tick(1); nmib = 1'b1;
                nmi_pend = 1'b1;
            end
            irqb = ~irq_low; i_flag = iflag;
            tick(S + 2);
            k = nmi_pend ? K_NMI : ((irq_low && !iflag) ? K_IRQ : K_NONE);
            if (int_pending !== (k != K_NONE)) begin
                errors++;
                $display("FAIL rand%0d_pending got=%b want=%b", it, int_pending, (k != K_NONE));
            end
            checks++;
            sync = 1'b1; tick(1); sync = 1'b0;
            if (k == K_NONE) begin
                if (obs() !== pk(5'b0, 1'b0, 16'h0, 1'b0)) begin
                    errors++;
                    $display("FAIL rand%0d_idle got=%h want=%h", it, obs(), pk(5'b0, 1'b0, 16'h0, 1'b0));
                end
                checks++;
            end else begin
                tick(dly);
                if (obs() !== pk(exp_ops(k), 1'b0, 16'h0, 1'b1)) begin
                    errors++;
                    $display("FAIL rand%0d_req got=%h want=%h", it, obs(), pk(exp_ops(k), 1'b0, 16'h0, 1'b1));
                end
                checks++;
                vec_ack = 1'b1; tick(1); vec_ack = 1'b0;
                if (k == K_NMI) nmi_pend = 1'b0;
                if (obs() !== pk(5'b0, 1'b1, exp_lo(k), 1'b1)) begin
                    errors++;
                    $display("FAIL rand%0d_lo got=%h want=%h", it, obs(), pk(5'b0, 1'b1, exp_lo(k), 1'b1));
                end
                checks++;
                tick(1);
                if (obs() !== pk(5'b0, 1'b1, exp_lo(k) + 16'd1, 1'b1)) begin
                    errors++;
                    $display("FAIL rand%0d_hi got=%h want=%h", it, obs(), pk(5'b0, 1'b1, exp_lo(k) + 16'd1, 1'b1));
                end
                checks++;
                tick(1);
                if (obs() !== pk(5'b0, 1'b0, 16'h0, 1'b0)) begin
                    errors++;
                    $display("FAIL rand%0d_end got=%h want=%h", it, obs(), pk(5'b0, 1'b0, 16'h0, 1'b0));
                end
                checks++;
            end
            irqb = 1'b1; i_flag = 1'b0;
            tick(S + 2);
        end
    endtask

    initial begin
        resb = 1'b0; irqb = 1'b1; nmib = 1'b1; rdy = 1'b1;
        sync = 1'b0; i_flag = 1'b0; vec_ack = 1'b0;
        test_reset();
        test_irq();
        test_nmi_priority();
        test_nmi_during_irq();
        test_rdy_stall();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
Front end of the 65C02 core's reset/interrupt path. It synchronises the external resb/irqb/nmib pins and arbitrates pending events at instruction boundaries. It issues the 5-bit vector-operation request consumed by instruction_decode ({push_vector, push_resb, push_nmib, push_irqb, reset_stack}), then runs the two-cycle vector-pull address sequence. It is the initiator side of the vector handshake that instruction_decode responds to.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the irqb/nmib synchronisers (legal 2..4).
RESET_CYCLES, 7, fclk cycles held in RST_HOLD after resb release before the reset vector is requested (legal 1..15).

Ports:
fclk  input  1  core clock; all state is updated on its rising edge.
resb  input  1  asynchronous, active-low reset; it is also the 65C02 RESB pin.
irqb  input  1  external IRQ pin, active-low, level-sensitive, asynchronous.
nmib  input  1  external NMI pin, active-low, falling-edge-sensitive, asynchronous.
rdy  input  1  high lets the sequence advance; low freezes state and outputs (counters included).
sync  input  1  instruction-boundary strobe from the decoder (opcode fetch cycle).
i_flag  input  1  the I bit (bit 2) of the processor status register.
vec_ack  input  1  single-cycle pulse from instruction_decode accepting the current vector request.
vector_operations  output  5  {push_vector, push_resb, push_nmib, push_irqb, reset_stack}.
vector_addr  output  16  vector fetch address, valid while vector_pull=1.
vector_pull  output  1  high during the two vector-fetch cycles; drives the core's VPB (inverted externally).
int_pending  output  1  an event is latched and waiting for a boundary.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset and clock: one clock, fclk. resb is asynchronous and active-low.
- While resb=0:
  - state=RST_HOLD, hold_cnt=0, nmi_latch=0.
  - Synchroniser flops are set to 1.
  - vector_operations=5'b00000, vector_addr=16'h0000, vector_pull=0, int_pending=0, busy=1.
- Synchronisers: irqb and nmib each pass through SYNC_STAGES flops; irq_s and nmi_s are the final-stage values.
- NMI latch:
  - nmi_latch sets on the cycle nmi_s goes from 1 to 0 (its previous-stage copy = 1, current = 0).
  - It clears on the vec_ack that accepts an NMI request.
  - An edge arriving on that same cycle wins: the latch stays set.
  - A held-low nmib generates exactly one request.
- IRQ condition: irq_req = ~irq_s & ~i_flag. It is never latched, so deasserting irqb before a boundary drops the request.
- int_pending = nmi_latch | irq_req, registered, and 0 outside IDLE.
- FSM states and actions (no transition occurs while rdy=0):
  - RST_HOLD: hold_cnt increments each cycle. At hold_cnt==RESET_CYCLES-1, kind=RESET and go to REQ.
  - IDLE: when sync=1, arbitrate NMI > IRQ. If nmi_latch, kind=NMI and go to REQ. Else if irq_req, kind=IRQ and go to REQ. With sync=0 or nothing pending, stay in IDLE.
  - REQ: vector_operations is held at RESET=5'b11001, NMI=5'b10100 or IRQ=5'b10010 until vec_ack=1. The cycle after vec_ack, vector_operations=0 and the FSM goes to VEC_LO.
  - VEC_LO: vector_pull=1; vector_addr = FFFC (RESET), FFFA (NMI) or FFFE (IRQ). Next state is VEC_HI.
  - VEC_HI: vector_pull=1; vector_addr = low address +1 (FFFD/FFFB/FFFF). Next state is IDLE, where vector_addr returns to 0 and vector_pull to 0.
- Output timing: all outputs are registered. vector_operations appears the cycle after the REQ entry decision, i.e. 1 cycle after the sync cycle that committed it.
- Commitment: once kind is chosen in REQ there is no hijack. An NMI edge during an IRQ sequence stays latched and is serviced at the next sync after returning to IDLE.
- vec_ack outside REQ is ignored.
- resb asserted mid-sequence: everything aborts immediately (asynchronously) to the reset values. After release, the full RESET_CYCLES hold runs again.
- i_flag is sampled only in IDLE; changes during REQ/VEC states have no effect.

Test Plan:
- Reset sequence: resb low 3 cycles, then high with rdy=1. Expect vector_operations=5'b11001 after 7 cycles in hold. After vec_ack, vector_pull=1 with vector_addr=16'hFFFC, then 16'hFFFD, then IDLE with busy=0.
- IRQ with I clear: irqb=0, i_flag=0, sync pulse. Expect 5'b10010 one cycle later, then FFFE/FFFF. Repeat with i_flag=1: no request and int_pending=0.
- NMI edge and priority: nmib falls and is held low, irqb=0 at the same time, then sync. Expect 5'b10100 and FFFA/FFFB. Holding nmib low through the next sync then produces an IRQ (5'b10010), not a second NMI.
- NMI during IRQ service: nmib pulse low for 1 cycle while in VEC_LO of an IRQ. The IRQ completes with FFFE/FFFF; the next sync yields 5'b10100.
- rdy stall: rdy=0 for 4 cycles in REQ and again in VEC_LO. Outputs hold (5'b10010; FFFE with vector_pull=1) and resume unchanged when rdy=1. With rdy low in RST_HOLD, hold_cnt freezes.
- Reset mid-operation: assert resb during VEC_HI of an NMI. Outputs clear in the same cycle with no clock edge needed, nmi_latch=0, and after release the reset vector FFFC/FFFD follows after 7 cycles.
